// File: rtl/osd_overlay_win.sv
// Character-cell OSD text window with colour/blink attributes, mixed over game video.
// Optional build macro OSD_SCALE2X_EN doubles every glyph pixel to 2x2 screen pixels.
module osd_overlay_win #(
    parameter int unsigned CHAR_WIDTH   = 8,
    parameter int unsigned CHAR_HEIGHT  = 8,
    parameter int unsigned SCREEN_COLS  = 48,
    parameter int unsigned SCREEN_ROWS  = 32,
    parameter int unsigned COLOR_BITS   = 4,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 hblank,
    input  logic                                 vblank,
    input  logic [9:0]                           x,
    input  logic [9:0]                           y,
    input  logic [3*COLOR_BITS-1:0]              video_in,
    input  logic                                 osd_enable,
    input  logic [9:0]                           win_x0,
    input  logic [9:0]                           win_y0,
    output logic [10:0]                          ram_addr,
    input  logic [7:0]                           char_code,
    input  logic [7:0]                           char_attr,
    output logic [8+$clog2(CHAR_HEIGHT)-1:0]     font_addr,
    input  logic [CHAR_WIDTH-1:0]                font_data,
    output logic [3*COLOR_BITS-1:0]              video_out,
    output logic                                 osd_pixel
);

    localparam int unsigned CW_LOG = $clog2(CHAR_WIDTH);
    localparam int unsigned CH_LOG = $clog2(CHAR_HEIGHT);
    localparam int unsigned VID_W  = 3 * COLOR_BITS;
    localparam int unsigned CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
`ifdef OSD_SCALE2X_EN
    localparam int unsigned WIN_W  = 2 * SCREEN_COLS * CHAR_WIDTH;
    localparam int unsigned WIN_H  = 2 * SCREEN_ROWS * CHAR_HEIGHT;
`else
    localparam int unsigned WIN_W  = SCREEN_COLS * CHAR_WIDTH;
    localparam int unsigned WIN_H  = SCREEN_ROWS * CHAR_HEIGHT;
`endif

    // ---------------- stage 0: window position decode ----------------
    logic [10:0]       rx_c;
    logic [10:0]       ry_c;
    logic [9:0]        px_c;
    logic [9:0]        py_c;
    logic              in_win_c;
    logic [5:0]        col_c;
    logic [4:0]        row_c;

    assign rx_c = {1'b0, x} - {1'b0, win_x0};
    assign ry_c = {1'b0, y} - {1'b0, win_y0};

`ifdef OSD_SCALE2X_EN
    assign px_c = {1'b0, rx_c[9:1]};
    assign py_c = {1'b0, ry_c[9:1]};
`else
    assign px_c = rx_c[9:0];
    assign py_c = ry_c[9:0];
`endif

    // Bit 10 is the sign of the 11-bit difference.
    assign in_win_c = ~rx_c[10] & ~ry_c[10]
                    & (32'(rx_c[9:0]) < WIN_W)
                    & (32'(ry_c[9:0]) < WIN_H);

    assign col_c    = 6'(px_c >> CW_LOG);
    assign row_c    = 5'(py_c >> CH_LOG);
    assign ram_addr = (in_win_c & reset_n) ? {row_c, col_c} : 11'd0;

    logic [CH_LOG-1:0] s0_gline;
    logic [CW_LOG-1:0] s0_gcol;
    logic              s0_in_win;
    logic              s0_active;
    logic              s0_en;
    logic [VID_W-1:0]  s0_video;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_gline  <= '0;
            s0_gcol   <= '0;
            s0_in_win <= 1'b0;
            s0_active <= 1'b0;
            s0_en     <= 1'b0;
            s0_video  <= '0;
        end else begin
            s0_gline  <= py_c[CH_LOG-1:0];
            s0_gcol   <= px_c[CW_LOG-1:0];
            s0_in_win <= in_win_c;
            s0_active <= ~hblank & ~vblank;
            s0_en     <= osd_enable;
            s0_video  <= video_in;
        end
    end

    // ---------------- stage 1: font fetch from RAM data ----------------
    assign font_addr = s0_in_win ? {char_code, s0_gline} : '0;

    logic [CW_LOG-1:0] s1_gcol;
    logic [7:0]        s1_attr;
    logic              s1_in_win;
    logic              s1_active;
    logic              s1_en;
    logic [VID_W-1:0]  s1_video;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_gcol   <= '0;
            s1_attr   <= '0;
            s1_in_win <= 1'b0;
            s1_active <= 1'b0;
            s1_en     <= 1'b0;
            s1_video  <= '0;
        end else begin
            s1_gcol   <= s0_gcol;
            s1_attr   <= char_attr;
            s1_in_win <= s0_in_win;
            s1_active <= s0_active;
            s1_en     <= s0_en;
            s1_video  <= s0_video;
        end
    end

    // ---------------- stage 2: glyph pixel select ----------------
    logic              s2_pix;
    logic [7:0]        s2_attr;
    logic              s2_in_win;
    logic              s2_active;
    logic              s2_en;
    logic [VID_W-1:0]  s2_video;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_pix    <= 1'b0;
            s2_attr   <= '0;
            s2_in_win <= 1'b0;
            s2_active <= 1'b0;
            s2_en     <= 1'b0;
            s2_video  <= '0;
        end else begin
            s2_pix    <= font_data[s1_gcol];
            s2_attr   <= s1_attr;
            s2_in_win <= s1_in_win;
            s2_active <= s1_active;
            s2_en     <= s1_en;
            s2_video  <= s1_video;
        end
    end

    // ---------------- blink frame counter ----------------
    logic             vblank_q;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q    <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            vblank_q <= vblank;
            if (vblank & ~vblank_q) begin
                if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + CNT_W'(1);
                end
            end
        end
    end

    // ---------------- stage 3: colour mix ----------------
    logic             vis_c;
    logic             fg_c;
    logic [VID_W-1:0] fg_rgb_c;
    logic [VID_W-1:0] bg_rgb_c;
    logic [VID_W-1:0] dark_c;
    logic [VID_W-1:0] vid_nxt;
    logic             osd_nxt;

    assign vis_c    = s2_active & s2_en & s2_in_win;
    assign fg_c     = s2_pix & ~(s2_attr[7] & blink_phase);
    assign fg_rgb_c = {{COLOR_BITS{s2_attr[2]}}, {COLOR_BITS{s2_attr[1]}}, {COLOR_BITS{s2_attr[0]}}};
    assign bg_rgb_c = {{COLOR_BITS{s2_attr[5]}}, {COLOR_BITS{s2_attr[4]}}, {COLOR_BITS{s2_attr[3]}}};

    // Halve each channel independently so no bit leaks across channel boundaries.
    always_comb begin
        dark_c = '0;
        for (int c = 0; c < 3; c++) begin
            dark_c[c*COLOR_BITS +: COLOR_BITS] = s2_video[c*COLOR_BITS +: COLOR_BITS] >> 1;
        end
    end

    always_comb begin
        vid_nxt = '0;
        osd_nxt = 1'b0;
        if (vis_c & fg_c) begin
            vid_nxt = fg_rgb_c;
            osd_nxt = 1'b1;
        end else if (vis_c & s2_attr[6]) begin
            vid_nxt = bg_rgb_c;
            osd_nxt = 1'b1;
        end else if (vis_c) begin
            vid_nxt = dark_c;
        end else if (s2_active) begin
            vid_nxt = s2_video;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            video_out <= '0;
            osd_pixel <= 1'b0;
        end else begin
            video_out <= vid_nxt;
            osd_pixel <= osd_nxt;
        end
    end

endmodule
